// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader boot stage.
//   - loader_state_e : loader FSM states (IDLE, LOAD, CHECK, RUN)
//   - DEPTH_DEF / ADDR_W_DEF : default image size and RAM address width
//   - CKSUM_W : width of the image checksum accumulator
//   - cksum_add() : modulo-256 checksum accumulation helper
package program_loader_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int CKSUM_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } loader_state_e;

    // Accumulate one image byte into the running checksum; overflow wraps mod 256.
    function automatic logic [CKSUM_W-1:0] cksum_add(input logic [CKSUM_W-1:0] acc,
                                                     input logic [7:0]         data);
        return acc + data;
    endfunction

endpackage

// File: rtl/program_loader_pin_sync_edge.sv
// pin_sync_edge: synchronizes one asynchronous pin into the clk domain and
// flags its rising edge.
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high (chain and edge flop cleared)
//   pin        : asynchronous pin level
//   sync_level : pin level after SYNC_STAGES flops
//   sync_rise  : high for one cycle when sync_level goes 0 -> 1
module pin_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync_level,
    output logic sync_rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_r[SYNC_STAGES-1];
    assign sync_rise  = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/program_loader.sv
// program_loader: boot stage that receives a DEPTH-byte program over a
// 4-phase strobe/ack byte handshake, writes it into CPU RAM and keeps the
// CPU in reset until a complete image has been loaded.
//   clk, rst     : clock and synchronous active-high reset
//   load_req     : async pin, high requests a load (low aborts a load)
//   strobe       : async pin, rising edge marks data_in valid
//   data_in      : program byte, stable from strobe rise until ack rise
//   ram_addr     : RAM write address
//   ram_wdata    : RAM write data
//   ram_we       : single-cycle RAM write pulse
//   cpu_hold     : high holds the CPU in reset
//   loaded       : high once a complete image is accepted
//   ack          : handshake acknowledge, drops after strobe drops
//   checksum_err : sticky checksum failure (constant 0 unless enabled)
// Build option: define LOADER_CHECKSUM_EN to accept a trailing checksum byte
// after the image; the mod-256 sum of all DEPTH+1 bytes must be zero.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              strobe,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              ack,
    output logic              checksum_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic load_req_s;
    logic load_req_rise_s;
    logic strobe_s;
    logic strobe_rise_s;

    loader_state_e     state_r,  state_nxt_s;
    logic [ADDR_W-1:0] count_r,  count_nxt_s;
    logic [ADDR_W-1:0] addr_r,   addr_nxt_s;
    logic [7:0]        wdata_r,  wdata_nxt_s;
    logic              we_r,     we_nxt_s;
    logic              hold_r,   hold_nxt_s;
    logic              loaded_r, loaded_nxt_s;
    logic              ack_r,    ack_nxt_s;
`ifdef LOADER_CHECKSUM_EN
    logic [CKSUM_W-1:0] sum_r,   sum_nxt_s;
    logic               phase_r, phase_nxt_s;   // data bytes done, expecting checksum byte
    logic               cerr_r,  cerr_nxt_s;
`endif

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_req_sync (
        .clk        (clk),
        .rst        (rst),
        .pin        (load_req),
        .sync_level (load_req_s),
        .sync_rise  (load_req_rise_s)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk        (clk),
        .rst        (rst),
        .pin        (strobe),
        .sync_level (strobe_s),
        .sync_rise  (strobe_rise_s)
    );

    // Next-state and registered-output logic for the loader FSM.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        we_nxt_s     = 1'b0;
        hold_nxt_s   = hold_r;
        loaded_nxt_s = loaded_r;
        ack_nxt_s    = ack_r;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt_s    = sum_r;
        phase_nxt_s  = phase_r;
        cerr_nxt_s   = cerr_r;
`endif

        // ack is released only once the host has dropped its strobe.
        if (!strobe_s) begin
            ack_nxt_s = 1'b0;
        end else begin
            ack_nxt_s = ack_r;
        end

        // The address counter advances the cycle after each write; it wraps
        // to 0 naturally after the last byte.
        if (we_r) begin
            count_nxt_s = count_r + 1'b1;
        end else begin
            count_nxt_s = count_r;
        end

        case (state_r)
            IDLE: begin
                hold_nxt_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                // After a checksum failure the error stays visible until the
                // host re-requests with a fresh load_req edge.
                if (load_req_s && (!cerr_r || load_req_rise_s)) begin
                    state_nxt_s  = LOAD;
                    count_nxt_s  = '0;
                    loaded_nxt_s = 1'b0;
                    sum_nxt_s    = '0;
                    phase_nxt_s  = 1'b0;
                    cerr_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s  = IDLE;
                end
`else
                if (load_req_s) begin
                    state_nxt_s  = LOAD;
                    count_nxt_s  = '0;
                    loaded_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = IDLE;
                end
`endif
            end

            LOAD: begin
                if (!load_req_s) begin
                    state_nxt_s  = IDLE;
                    count_nxt_s  = '0;
                    loaded_nxt_s = 1'b0;
                end else if (we_r && (count_r == LAST_ADDR)) begin
`ifdef LOADER_CHECKSUM_EN
                    phase_nxt_s  = 1'b1;
`else
                    state_nxt_s  = RUN;
                    hold_nxt_s   = 1'b0;
                    loaded_nxt_s = 1'b1;
`endif
                end else if (strobe_rise_s && !ack_r) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt_s = cksum_add(sum_r, data_in);
                    ack_nxt_s = 1'b1;
                    if (phase_r) begin
                        state_nxt_s = CHECK;
                    end else begin
                        wdata_nxt_s = data_in;
                        addr_nxt_s  = count_r;
                        we_nxt_s    = 1'b1;
                    end
`else
                    wdata_nxt_s = data_in;
                    addr_nxt_s  = count_r;
                    we_nxt_s    = 1'b1;
                    ack_nxt_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = LOAD;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (!load_req_s) begin
                    state_nxt_s  = IDLE;
                    count_nxt_s  = '0;
                    loaded_nxt_s = 1'b0;
                end else if (sum_r == {CKSUM_W{1'b0}}) begin
                    state_nxt_s  = RUN;
                    hold_nxt_s   = 1'b0;
                    loaded_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = IDLE;
                    cerr_nxt_s   = 1'b1;
                end
            end
`endif

            RUN: begin
                hold_nxt_s   = 1'b0;
                loaded_nxt_s = 1'b1;
                if (load_req_rise_s) begin
                    state_nxt_s  = LOAD;
                    hold_nxt_s   = 1'b1;
                    loaded_nxt_s = 1'b0;
                    count_nxt_s  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt_s    = '0;
                    phase_nxt_s  = 1'b0;
                    cerr_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s  = RUN;
                end
            end

            default: begin
                state_nxt_s  = IDLE;
                count_nxt_s  = '0;
                hold_nxt_s   = 1'b1;
                loaded_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset cancels any write pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= '0;
            addr_r   <= '0;
            wdata_r  <= 8'h00;
            we_r     <= 1'b0;
            hold_r   <= 1'b1;
            loaded_r <= 1'b0;
            ack_r    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_r    <= '0;
            phase_r  <= 1'b0;
            cerr_r   <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            we_r     <= we_nxt_s;
            hold_r   <= hold_nxt_s;
            loaded_r <= loaded_nxt_s;
            ack_r    <= ack_nxt_s;
`ifdef LOADER_CHECKSUM_EN
            sum_r    <= sum_nxt_s;
            phase_r  <= phase_nxt_s;
            cerr_r   <= cerr_nxt_s;
`endif
        end
    end

    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;
    assign ram_we    = we_r;
    assign cpu_hold  = hold_r;
    assign loaded    = loaded_r;
    assign ack       = ack_r;
`ifdef LOADER_CHECKSUM_EN
    assign checksum_err = cerr_r;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the 8-bit CPU. It accepts a 16-byte program from the chip pins over an asynchronous strobe/ack byte handshake and writes each byte into the CPU RAM. It holds the CPU in reset until a complete image is loaded, then releases it. It sits between the dedicated input pins and the RAM write port / CPU reset.

## Interface
Parameters:
- DEPTH, 16, number of RAM bytes in one image
- ADDR_W, 4, RAM address width; must satisfy 2**ADDR_W == DEPTH
- SYNC_STAGES, 2, flops in each pin synchronizer; minimum 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- load_req  in  1  pin level, asynchronous; high requests a program load
- strobe  in  1  pin level, asynchronous; rising edge means data_in is valid
- data_in  in  8  program byte; must stay stable from strobe rise until ack rises
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  single-cycle write pulse
- cpu_hold  out  1  high holds the CPU in reset
- loaded  out  1  high once a complete image has been accepted
- ack  out  1  4-phase handshake acknowledge to the host
- checksum_err  out  1  sticky checksum failure; tied 0 without the macro

## Operation
- load_req and strobe each pass through a SYNC_STAGES synchronizer. strobe also has a rising-edge detect flop; its output is strobe_rise.
- States are IDLE, LOAD, CHECK (present only with the macro), and RUN.
- Reset values: state IDLE, count 0, ram_addr 0, ram_wdata 0, ram_we 0, cpu_hold 1, loaded 0, ack 0, checksum_err 0.
- IDLE: cpu_hold=1. When load_req_s=1, go to LOAD with count=0 and loaded=0.
- LOAD: each strobe_rise does the following:
  - captures data_in into ram_wdata;
  - sets ram_addr=count and pulses ram_we for 1 cycle;
  - sets ack=1;
  - increments count on the following cycle.
- ack stays high until strobe_s falls, then returns to 0. A strobe_rise while ack=1 is impossible under the 4-phase protocol; if it occurs anyway, it is ignored.
- After byte DEPTH-1 is written, the next state is RUN, or CHECK with the macro. count wraps to 0 and no further RAM writes occur.
- RUN: cpu_hold=0, loaded=1. A new load_req_s rising edge (0→1 while in RUN) returns the block to LOAD with cpu_hold=1 and loaded=0. This allows a reload without a chip reset.
- Abort: if load_req_s falls while in LOAD or CHECK, the block returns to IDLE, count resets to 0, and loaded stays 0. Bytes already written are left in RAM.
- rst in any state returns the block to IDLE on the next clock edge. A ram_we pulse in flight is cancelled.

## Timing
- strobe pin rise to ram_we: SYNC_STAGES+1 clock edges (3 by default). ram_wdata and ram_addr are valid in the same cycle as ram_we.
- ack rises together with ram_we. ack falls SYNC_STAGES+1 edges after the strobe pin falls.
- Final write to cpu_hold=0: 1 cycle without the macro. With the macro, the last strobe accepted (the checksum byte) is followed by CHECK for 1 cycle, then RUN.
- Maximum throughput: one byte per 2·(SYNC_STAGES+1)+2 clocks.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - after DEPTH data bytes, one extra byte is accepted with an ack but is not written to RAM;
  - the 8-bit sum of all DEPTH+1 bytes, taken mod 256, must be 0;
  - pass: CHECK → RUN;
  - fail: checksum_err=1, CHECK → IDLE, cpu_hold stays 1;
  - checksum_err clears on rst or on the next LOAD entry.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no accumulator, checksum_err tied 0, and RUN is entered directly after byte DEPTH-1.

## Structure
- Shared package: the loader state enum (IDLE, LOAD, CHECK, RUN), the DEPTH/ADDR_W defaults, and the checksum width constant.
- One sub-module, pin_sync_edge, parameterized on SYNC_STAGES. It outputs the synchronized level and a rise pulse, and is instantiated once for load_req and once for strobe.

## Test plan
- Reset then load_req=1 with 16 bytes 0x10..0x1F → 16 ram_we pulses at addr 0..15 with matching data, then loaded=1 and cpu_hold=0.
- load_req dropped after 5 bytes → IDLE, cpu_hold=1, loaded=0; a new load writes again starting at addr 0.
- rst asserted in the cycle of the 3rd strobe_rise → no ram_we in that cycle; all outputs at reset values on the next cycle.
- In RUN, load_req toggled 0→1 → cpu_hold=1, loaded=0 next cycle, and reload begins at addr 0.
- Handshake timing: strobe rise → ram_we and ack after exactly 3 clocks; strobe fall → ack=0 after exactly 3 clocks; a held strobe produces only one write.
- LOADER_CHECKSUM_EN: bytes 0x01×16 plus checksum 0xF0 → RUN. The same data plus checksum 0xF1 → checksum_err=1, IDLE, cpu_hold=1, and no 17th RAM write.
